// File: rtl/oclib_uart_framed.sv
// UART with compile-time frame format (5..9 data bits, none/odd/even parity, 1/2 stop bits),
// runtime baud divisor and an oversampled, majority-voted receiver with error reporting.
//
// TX state | meaning
// IDLE     | txReady high, waiting for a character
// START    | driving the start bit (0)
// DATA     | shifting data bits out LSB first
// PARITY   | driving the parity bit
// STOP     | driving StopBits stop bits (1)
//
// RX state  | meaning
// IDLE      | waiting for a synchronized 0
// START     | validating the start bit at mid-bit
// DATA      | sampling data bits
// PARITY    | sampling the parity bit
// STOP      | mid-stop decision: deliver, framing error or break
// WAIT_HIGH | after a break, waiting for the line to return high
module oclib_uart_framed #(
  parameter int DataBits   = 8,
  parameter int Parity     = 0,
  parameter int StopBits   = 1,
  parameter int Oversample = 16,
  parameter int DivWidth   = 16,
  parameter int SyncCycles = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [DivWidth-1:0] baudDiv,
  input  logic                rx,
  output logic                tx,
  input  logic [DataBits-1:0] txData,
  input  logic                txValid,
  output logic                txReady,
  output logic [DataBits-1:0] rxData,
  output logic                rxValid,
  input  logic                rxReady,
  output logic [3:0]          error
);

  localparam int OsW = $clog2(Oversample);
  localparam logic [OsW-1:0] OS_LAST = OsW'(Oversample - 1);
  localparam logic [OsW-1:0] MID_A   = OsW'(Oversample / 2 - 1);
  localparam logic [OsW-1:0] MID_B   = OsW'(Oversample / 2);
  localparam logic [OsW-1:0] MID_C   = OsW'(Oversample / 2 + 1);
  localparam logic [3:0]     DATA_LAST = 4'(DataBits - 1);
  localparam logic [3:0]     STOP_LAST = 4'(StopBits - 1);
  localparam logic           ODD = (Parity == 1);

  // tick generator; the divisor is latched at each wrap so a change applies to the next period
  logic [DivWidth-1:0] div_cnt;
  logic [DivWidth-1:0] div_lat;
  logic                tick;

  assign tick = (div_cnt == div_lat);

  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt <= '0;
      div_lat <= baudDiv;
    end else if (tick) begin
      div_cnt <= '0;
      div_lat <= baudDiv;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // ---------------- transmitter ----------------
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

  tx_state_t           tx_state, tx_next;
  logic [OsW-1:0]      tx_os;
  logic [3:0]          tx_cnt;
  logic [DataBits-1:0] tx_sh;
  logic                tx_par;
  logic                tx_bit_end;
  logic                tx_line;

  assign tx_bit_end = tick && (tx_os == OS_LAST);
  assign txReady    = (tx_state == TX_IDLE) && !reset;
  assign tx         = reset ? 1'b1 : tx_line;

  always_comb begin
    tx_next = tx_state;
    tx_line = 1'b1;
    case (tx_state)
      TX_IDLE:   if (txValid) tx_next = TX_START;
      TX_START: begin
        tx_line = 1'b0;
        if (tx_bit_end) tx_next = TX_DATA;
      end
      TX_DATA: begin
        tx_line = tx_sh[0];
        if (tx_bit_end && tx_cnt == DATA_LAST) tx_next = (Parity != 0) ? TX_PARITY : TX_STOP;
      end
      TX_PARITY: begin
        tx_line = tx_par;
        if (tx_bit_end) tx_next = TX_STOP;
      end
      TX_STOP:   if (tx_bit_end && tx_cnt == STOP_LAST) tx_next = TX_IDLE;
      default:   tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_os    <= '0;
      tx_cnt   <= '0;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
    end else begin
      tx_state <= tx_next;
      if (tx_state == TX_IDLE) begin
        tx_os  <= '0;
        tx_cnt <= '0;
        if (txValid) begin
          tx_sh  <= txData;
          tx_par <= (^txData) ^ ODD;
        end
      end else if (tick) begin
        tx_os <= tx_bit_end ? '0 : tx_os + 1'b1;
        if (tx_bit_end) begin
          tx_cnt <= (tx_next != tx_state) ? '0 : tx_cnt + 1'b1;
          if (tx_state == TX_DATA) tx_sh <= tx_sh >> 1;
        end
      end
    end
  end

  // ---------------- receiver ----------------
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  logic [SyncCycles-1:0] rx_sync;
  logic                  rx_s;
  rx_state_t             rx_state, rx_next;
  logic [OsW-1:0]        rx_os;
  logic [3:0]            rx_cnt;
  logic [DataBits-1:0]   rx_sh;
  logic                  rx_parbit;
  logic                  rx_v0, rx_v1, rx_maj;
  logic                  rx_mid, rx_end;
  logic                  stop_dec, brk_c, frm_c, good_c, par_c, ovr_c;

  assign rx_s   = rx_sync[SyncCycles-1];
  assign rx_mid = tick && (rx_os == MID_C);
  assign rx_end = tick && (rx_os == OS_LAST);
  assign rx_maj = (rx_v0 & rx_v1) | (rx_v0 & rx_s) | (rx_v1 & rx_s);

  always_comb begin
    rx_next  = rx_state;
    stop_dec = (rx_state == RX_STOP) && rx_mid;
    brk_c    = stop_dec && !rx_maj && (rx_sh == '0) && ((Parity == 0) || !rx_parbit);
    frm_c    = stop_dec && !rx_maj && !brk_c;
    good_c   = stop_dec && rx_maj;
    par_c    = good_c && (Parity != 0) && (rx_parbit != ((^rx_sh) ^ ODD));
    ovr_c    = good_c && rxValid && !rxReady;
    case (rx_state)
      RX_IDLE:      if (!rx_s) rx_next = RX_START;
      RX_START: begin
        if (rx_mid && rx_maj) rx_next = RX_IDLE;
        else if (rx_end)      rx_next = RX_DATA;
      end
      RX_DATA:      if (rx_end && rx_cnt == DATA_LAST) rx_next = (Parity != 0) ? RX_PARITY : RX_STOP;
      RX_PARITY:    if (rx_end) rx_next = RX_STOP;
      RX_STOP:      if (rx_mid) rx_next = brk_c ? RX_WAIT_HIGH : RX_IDLE;
      RX_WAIT_HIGH: if (rx_s) rx_next = RX_IDLE;
      default:      rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_sync   <= '1;
      rx_state  <= RX_IDLE;
      rx_os     <= '0;
      rx_cnt    <= '0;
      rx_sh     <= '0;
      rx_parbit <= 1'b0;
      rx_v0     <= 1'b1;
      rx_v1     <= 1'b1;
      rxData    <= '0;
      rxValid   <= 1'b0;
      error     <= '0;
    end else begin
      rx_sync  <= {rx_sync[SyncCycles-2:0], rx};
      rx_state <= rx_next;
      error    <= {brk_c, ovr_c, par_c, frm_c};
      if (rx_state == RX_IDLE) begin
        rx_os  <= '0;
        rx_cnt <= '0;
      end else if (tick) begin
        rx_os <= rx_end ? '0 : rx_os + 1'b1;
        if (rx_os == MID_A) rx_v0 <= rx_s;
        if (rx_os == MID_B) rx_v1 <= rx_s;
        if (rx_mid && rx_state == RX_DATA)   rx_sh <= {rx_maj, rx_sh[DataBits-1:1]};
        if (rx_mid && rx_state == RX_PARITY) rx_parbit <= rx_maj;
        if (rx_end && rx_state == RX_DATA)   rx_cnt <= rx_cnt + 1'b1;
      end
      // single-entry output register: a full, unconsumed entry keeps its old character
      if (good_c && !(rxValid && !rxReady)) begin
        rxData  <= rx_sh;
        rxValid <= 1'b1;
      end else if (rxValid && rxReady) begin
        rxValid <= 1'b0;
      end
    end
  end

endmodule
